// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches words from a synchronous instruction memory, decodes add/sub/sd,
// and issues one op at a time to the datapath, holding it until ex_done.
module instruction_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int PROG_LEN = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    input  logic              ex_done,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [6:0]        op_code,
    output logic              issue_valid,
    output logic              illegal,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_HALT} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [4:0]        r_rs1, r_rs2, r_rd;
    logic [6:0]        r_op, w_op;
    logic              r_illegal, w_zero, w_last, w_bad, w_advance;

    assign w_zero = imem_data == 32'h0;
    assign w_last = r_pc == LAST_PC;
    assign w_op   = (imem_data[6:0] == 7'b0110011 && imem_data[14:12] == 3'b000) ?
                        (imem_data[31:25] == 7'b0000000 ? 7'd2 :
                         imem_data[31:25] == 7'b0100000 ? 7'd3 : 7'd0) :
                    (imem_data[6:0] == 7'b0100011 && imem_data[14:12] == 3'b011) ? 7'd1 : 7'd0;
    assign w_bad  = r_state == S_DECODE && !w_zero && w_op == 7'd0;
    // Both a skipped illegal word and a completed issue move on to the next slot
    assign w_advance = w_bad || (r_state == S_ISSUE && ex_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT: w_next = start ? S_FETCH : r_state;
            S_FETCH:        w_next = S_DECODE;
            S_DECODE:       w_next = w_zero ? S_HALT : w_op != 7'd0 ? S_ISSUE : w_last ? S_HALT : S_FETCH;
            S_ISSUE:        w_next = !ex_done ? S_ISSUE : w_last ? S_HALT : S_FETCH;
            default:        w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
            r_op      <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_bad;
            if ((r_state == S_IDLE || r_state == S_HALT) && start)
                r_pc <= '0;
            else if (w_advance && !w_last)
                r_pc <= r_pc + ADDR_W'(1);
            if (r_state == S_DECODE && w_op != 7'd0) begin
                r_rs1 <= imem_data[19:15];
                r_rs2 <= imem_data[24:20];
                r_rd  <= imem_data[11:7];
                r_op  <= w_op;
            end else if (r_state == S_ISSUE && ex_done) begin
                r_op <= 7'd0;
            end
        end
    end

    always_comb begin
        issue_valid = r_state == S_ISSUE;
        halted      = r_state == S_HALT;
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign op_code   = r_op;
    assign illegal   = r_illegal;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: program-level reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized programs.
`timescale 1ns/1ps
module tb_instruction_sequencer;
    localparam int AW = 3;
    localparam int PL = 4;

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, ex_done = 1'b0;
    logic [AW-1:0] imem_addr, pc;
    logic [31:0]   imem_data = 32'h0;
    logic [4:0]    rs1, rs2, rd;
    logic [6:0]    op_code;
    logic          issue_valid, illegal, halted;
    logic [31:0]   mem [PL];
    int            checks = 0, errors = 0;

    bit m_run, m_issue, m_ill, m_halt;
    int m_pc, m_lat, m_op, m_rs1, m_rs2, m_rd;

    instruction_sequencer #(.ADDR_W(AW), .PROG_LEN(PL)) dut (
        .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_data(imem_data),
        .ex_done(ex_done), .rs1(rs1), .rs2(rs2), .rd(rd), .op_code(op_code),
        .issue_valid(issue_valid), .illegal(illegal), .halted(halted), .pc(pc)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) imem_data <= (imem_addr < AW'(PL)) ? mem[imem_addr[1:0]] : 32'hDEAD_BEEF;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] rtype(logic [6:0] f7, logic [4:0] b, logic [4:0] a, logic [4:0] d);
        return {f7, b, a, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] stype(logic [6:0] hi, logic [4:0] b, logic [4:0] a, logic [4:0] lo);
        return {hi, b, a, 3'b011, lo, 7'b0100011};
    endfunction

    function automatic int dec(logic [31:0] w);
        if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h00) return 2;
        if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'h20) return 3;
        if (w[6:0] == 7'h23 && w[14:12] == 3'd3) return 1;
        return 0;
    endfunction

    task automatic chk(string n, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", n, a, e);
        end
    endtask

    task automatic m_advance();
        if (m_pc == PL - 1) begin
            m_run = 0;
            m_halt = 1;
        end else begin
            m_pc++;
            m_lat = 2;
        end
    endtask

    // Program-level model: after each slot is chosen the word is judged two cycles later
    initial begin : model
        logic [31:0] w;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_run = 0; m_issue = 0; m_ill = 0; m_halt = 0;
                m_pc = 0; m_lat = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            end else begin
                m_ill = 0;
                if (!m_run) begin
                    if (start) begin
                        m_run = 1; m_halt = 0; m_pc = 0; m_lat = 2;
                    end
                end else if (!m_issue) begin
                    m_lat--;
                    if (m_lat == 0) begin
                        w = mem[m_pc];
                        if (w == 32'h0) begin
                            m_run = 0;
                            m_halt = 1;
                        end else if (dec(w) != 0) begin
                            m_issue = 1; m_op = dec(w);
                            m_rs1 = int'(w[19:15]); m_rs2 = int'(w[24:20]); m_rd = int'(w[11:7]);
                        end else begin
                            m_ill = 1;
                            m_advance();
                        end
                    end
                end else if (ex_done) begin
                    m_issue = 0;
                    m_op = 0;
                    m_advance();
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            chk("issue_valid", int'(issue_valid), int'(m_issue));
            chk("op_code", int'(op_code), m_op);
            chk("illegal", int'(illegal), int'(m_ill));
            chk("halted", int'(halted), int'(m_halt));
            chk("pc", int'(pc), m_pc);
            chk("imem_addr", int'(imem_addr), m_pc);
            if (m_issue) begin
                chk("rs1", int'(rs1), m_rs1);
                chk("rs2", int'(rs2), m_rs2);
                chk("rd", int'(rd), m_rd);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_op();
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
    endtask

    task automatic wait_issue(output int n, output int ill);
        n = 1;
        ill = int'(illegal);
        while (!issue_valid && n < 60) begin
            tick();
            n++;
            ill += int'(illegal);
        end
        chk("issue_seen", int'(issue_valid), 1);
    endtask

    task automatic wait_halt();
        int n = 0;
        while (!halted && n < 60) begin
            tick();
            n++;
        end
        chk("halt_seen", int'(halted), 1);
    endtask

    initial begin
        int n, ill;
        foreach (mem[i]) mem[i] = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_issue", int'(issue_valid), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_op", int'(op_code), 0);
        chk("rst_illegal", int'(illegal), 0);

        // add x1,x2,x3 then another add, then halt word
        mem[0] = 32'h003100B3; mem[1] = rtype(7'h00, 5'd7, 5'd6, 5'd5); mem[2] = 32'h0;
        do_start();
        wait_issue(n, ill);
        chk("t1_latency", n, 3);
        chk("t1_op", int'(op_code), 2);
        chk("t1_rs1", int'(rs1), 2);
        chk("t1_rs2", int'(rs2), 3);
        chk("t1_rd", int'(rd), 1);
        repeat (3) tick();
        chk("t1_held", int'(issue_valid), 1);
        finish_op();
        chk("t1_pc", int'(pc), 1);
        chk("t1_drop", int'(issue_valid), 0);
        wait_issue(n, ill);
        chk("t1_relat", n, 3);
        chk("t1_rs1b", int'(rs1), 6);
        finish_op();
        wait_halt();

        do_reset();
        mem[0] = 32'h40520733; mem[1] = 32'h0;
        do_start();
        wait_issue(n, ill);
        chk("t2_op", int'(op_code), 3);
        chk("t2_rs1", int'(rs1), 4);
        chk("t2_rs2", int'(rs2), 5);
        chk("t2_rd", int'(rd), 14);
        finish_op();
        wait_halt();
        chk("t2_op0", int'(op_code), 0);
        chk("t2_pc", int'(pc), 1);

        do_reset();
        mem[0] = 32'hFFFFFFFF; mem[1] = 32'h003100B3; mem[2] = 32'h0;
        do_start();
        wait_issue(n, ill);
        chk("t3_latency", n, 5);
        chk("t3_illegal_cycles", ill, 1);
        chk("t3_pc", int'(pc), 1);
        chk("t3_op", int'(op_code), 2);
        finish_op();
        wait_halt();

        do_reset();
        mem[0] = rtype(7'h00, 5'd9, 5'd8, 5'd7); mem[1] = rtype(7'h20, 5'd12, 5'd11, 5'd10); mem[2] = 32'h0;
        do_start();
        wait_issue(n, ill);
        repeat (20) begin
            tick();
            chk("t4_hold_rd", int'(rd), 7);
        end
        finish_op();
        finish_op();
        finish_op();
        wait_issue(n, ill);
        chk("t4_pc_once", int'(pc), 1);
        chk("t4_op", int'(op_code), 3);
        chk("t4_rd", int'(rd), 10);
        finish_op();
        wait_halt();

        do_reset();
        for (int i = 0; i < PL; i++) mem[i] = rtype(7'h00, 5'(i + 1), 5'(i + 2), 5'(i + 3));
        do_start();
        for (int i = 0; i < PL; i++) begin
            wait_issue(n, ill);
            chk("t5_pc", int'(pc), i);
            chk("t5_rd", int'(rd), i + 3);
            finish_op();
        end
        chk("t5_halted", int'(halted), 1);
        chk("t5_last_pc", int'(pc), 3);
        do_start();
        wait_issue(n, ill);
        chk("t5_restart_pc", int'(pc), 0);

        do_reset();
        do_start();
        repeat (2) begin
            wait_issue(n, ill);
            finish_op();
        end
        wait_issue(n, ill);
        chk("t6_pc", int'(pc), 2);
        reset = 1'b1;
        #1;
        chk("t6_issue", int'(issue_valid), 0);
        chk("t6_op", int'(op_code), 0);
        chk("t6_rs1", int'(rs1), 0);
        chk("t6_rs2", int'(rs2), 0);
        chk("t6_rd", int'(rd), 0);
        chk("t6_pc0", int'(pc), 0);
        chk("t6_halted", int'(halted), 0);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_idle_issue", int'(issue_valid), 0);
        do_start();
        wait_issue(n, ill);
        chk("t6_restart_lat", n, 3);
        chk("t6_restart_pc", int'(pc), 0);

        for (int it = 0; it < 40; it++) begin
            do_reset();
            foreach (mem[i]) begin
                int k = int'($urandom_range(0, 9));
                mem[i] = k == 0 ? 32'h0 :
                         k <= 2 ? $urandom :
                         k <= 5 ? rtype(7'h00, 5'($urandom), 5'($urandom), 5'($urandom)) :
                         k <= 7 ? rtype(7'h20, 5'($urandom), 5'($urandom), 5'($urandom)) :
                                  stype(7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            end
            repeat (120) begin
                start = ($urandom % 8) == 0;
                ex_done = ($urandom % 3) == 0;
                reset = ($urandom % 150) == 0;
                tick();
            end
            start = 1'b0;
            ex_done = 1'b0;
            reset = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
